baud_rate_generator_frac: RTL

Runtime-programmable fractional baud tick generator for the UART path. It produces an oversampling tick (os_tick) for the RX sampler and a bit-rate tick (bit_tick) for the TX shifter. The divisor is set by an integer part plus a fractional part, and can be reloaded at runtime through a load/busy handshake. A sync_clear input realigns the phase to an RX start-bit edge.

---
 rtl/baud_pkg.sv | 30 +++
 rtl/baud_frac_acc.sv | 36 +++
 rtl/baud_rate_generator_frac.sv | 136 +++++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared constants and helpers for the fractional baud tick generator.
package baud_pkg;

    localparam int unsigned MIN_DIV_INT = 2;

    typedef struct packed {
        logic [31:0] div_int;
        logic [31:0] div_frac;
    } div_pair_t;

    // round(clock_freq * 2^frac_w / (baud * oversample)), split into int/frac.
    function automatic div_pair_t default_div(input longint unsigned clock_freq,
                                              input longint unsigned baud,
                                              input longint unsigned oversample,
                                              input int unsigned     frac_w);
        longint unsigned den;
        longint unsigned total;
        div_pair_t       pair;
        den           = baud * oversample;
        total         = ((clock_freq << frac_w) + den / 2) / den;
        pair.div_int  = 32'(total >> frac_w);
        pair.div_frac = 32'(total & ((64'd1 << frac_w) - 64'd1));
        return pair;
    endfunction

    function automatic int unsigned os_cnt_w(input int unsigned oversample);
        return $clog2(oversample);
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds div_frac per os period and flags when the
// next period must be stretched by one clock.
module baud_frac_acc #(
    parameter int unsigned DIV_FRAC_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  add_en_i,
    input  logic [DIV_FRAC_W-1:0] div_frac_i,
    output logic                  carry_o,
    output logic                  extend_o
);

    logic [DIV_FRAC_W-1:0] acc_q;
    logic                  extend_q;
    logic [DIV_FRAC_W:0]   sum;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, div_frac_i};
        carry_o = sum[DIV_FRAC_W];
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            acc_q    <= '0;
            extend_q <= 1'b0;
        end else if (add_en_i) begin
            acc_q    <= sum[DIV_FRAC_W-1:0];
            extend_q <= carry_o;
        end
    end

    assign extend_o = extend_q;

endmodule

// File: rtl/baud_rate_generator_frac.sv
// Runtime-programmable fractional baud generator producing oversample and bit ticks,
// with a shadowed divisor load and phase realignment on sync_clear.
module baud_rate_generator_frac
    import baud_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ   = 50000000,
    parameter int unsigned DEFAULT_BAUD = 19200,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_INT_W    = 16,
    parameter int unsigned DIV_FRAC_W   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_i,
    input  logic [DIV_INT_W-1:0]          div_int_i,
    input  logic [DIV_FRAC_W-1:0]         div_frac_i,
    input  logic                          div_load_i,
    output logic                          div_busy_o,
    input  logic                          sync_clear_i,
    output logic                          os_tick_o,
    output logic                          bit_tick_o,
    output logic [$clog2(OVERSAMPLE)-1:0] os_count_o
);

    localparam int unsigned OsCntW = os_cnt_w(OVERSAMPLE);
    localparam div_pair_t DefDiv = default_div(CLOCK_FREQ, DEFAULT_BAUD, OVERSAMPLE, DIV_FRAC_W);
    localparam logic [DIV_INT_W-1:0]  DefInt  = DIV_INT_W'(DefDiv.div_int);
    localparam logic [DIV_FRAC_W-1:0] DefFrac = DIV_FRAC_W'(DefDiv.div_frac);
    localparam logic [DIV_INT_W-1:0]  MinInt  = DIV_INT_W'(MIN_DIV_INT);
    localparam logic [OsCntW-1:0]     OsLast  = OsCntW'(OVERSAMPLE - 1);

    logic [DIV_INT_W-1:0]  cnt_q;
    logic [OsCntW-1:0]     os_cnt_q;
    logic                  os_tick_q;
    logic                  bit_tick_q;
    logic                  busy_q;
    logic [DIV_INT_W-1:0]  act_int_q;
    logic [DIV_FRAC_W-1:0] act_frac_q;
    logic [DIV_INT_W-1:0]  sh_int_q;
    logic [DIV_FRAC_W-1:0] sh_frac_q;

    logic                  capture;
    logic                  boundary;
    logic                  extend;
    logic                  carry;
    logic [DIV_INT_W-1:0]  eff_int;
    logic [DIV_INT_W:0]    period;
    logic [DIV_FRAC_W-1:0] nxt_frac;

    always_comb begin
        capture  = div_load_i && !busy_q;
        eff_int  = (act_int_q < MinInt) ? MinInt : act_int_q;
        period   = {1'b0, eff_int} + {{DIV_INT_W{1'b0}}, extend};
        // >= rather than == so a divisor swapped in while frozen cannot strand the counter
        boundary = enable_i && (({1'b0, cnt_q} + (DIV_INT_W + 1)'(1)) >= period);
        // The fraction governing the coming period is the one added at its start
        nxt_frac = busy_q ? sh_frac_q : act_frac_q;
    end

    baud_frac_acc #(
        .DIV_FRAC_W (DIV_FRAC_W)
    ) u_frac_acc (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (sync_clear_i),
        .add_en_i   (boundary && !sync_clear_i),
        .div_frac_i (nxt_frac),
        .carry_o    (carry),
        .extend_o   (extend)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            busy_q     <= 1'b0;
            act_int_q  <= DefInt;
            act_frac_q <= DefFrac;
            sh_int_q   <= '0;
            sh_frac_q  <= '0;
        end else if (sync_clear_i) begin
            // Counter reloads at 1 so the next tick lands div_int cycles after the clear
            cnt_q      <= DIV_INT_W'(1);
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            busy_q     <= 1'b0;
            if (capture) begin
                sh_int_q   <= div_int_i;
                sh_frac_q  <= div_frac_i;
                act_int_q  <= div_int_i;
                act_frac_q <= div_frac_i;
            end else if (busy_q) begin
                act_int_q  <= sh_int_q;
                act_frac_q <= sh_frac_q;
            end
        end else begin
            if (capture) begin
                sh_int_q  <= div_int_i;
                sh_frac_q <= div_frac_i;
                busy_q    <= 1'b1;
            end
            if (!enable_i) begin
                os_tick_q  <= 1'b0;
                bit_tick_q <= 1'b0;
                if (busy_q) begin
                    act_int_q  <= sh_int_q;
                    act_frac_q <= sh_frac_q;
                    busy_q     <= 1'b0;
                end
            end else if (boundary) begin
                cnt_q      <= '0;
                os_tick_q  <= 1'b1;
                bit_tick_q <= (os_cnt_q == OsLast);
                os_cnt_q   <= os_cnt_q + OsCntW'(1);
                if (busy_q) begin
                    act_int_q  <= sh_int_q;
                    act_frac_q <= sh_frac_q;
                    busy_q     <= 1'b0;
                end
            end else begin
                cnt_q      <= cnt_q + DIV_INT_W'(1);
                os_tick_q  <= 1'b0;
                bit_tick_q <= 1'b0;
            end
        end
    end

    assign div_busy_o = busy_q;
    assign os_tick_o  = os_tick_q;
    assign bit_tick_o = bit_tick_q;
    assign os_count_o = os_cnt_q;

endmodule
